// File: rtl/psum_writeback.sv
// Partial-sum writeback: pops OFIFO rows, optionally accumulates them onto the
// current SRAM contents with per-lane saturation and ReLU, and writes them back.
module psum_writeback #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int aw      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [aw:0]              n_rows,
  input  logic [aw-1:0]            base_addr,
  input  logic                     acc_en,
  input  logic                     relu_en,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [aw-1:0]            sram_addr,
  output logic [col*psum_bw-1:0]   sram_d,
  input  logic [col*psum_bw-1:0]   sram_q,
  output logic                     busy,
  output logic                     done,
  output logic                     sat_flag
);

  localparam int W = col * psum_bw;
  localparam logic [psum_bw-1:0] MAX_V = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] MIN_V = {1'b1, {(psum_bw-1){1'b0}}};
  localparam logic [aw:0]        ONE   = (aw+1)'(1);

  typedef enum logic [2:0] {IDLE, POP, ACC, WR, FIN} state_t;

  state_t          state_q, state_d;
  logic [aw:0]     n_q, n_d, idx_q, idx_d;
  logic [aw-1:0]   base_q, base_d;
  logic            acc_q, acc_d, relu_q, relu_d, sat_q, sat_d;
  logic [W-1:0]    row_q, row_d, res_q, res_d;

  logic [aw-1:0]   row_addr;
  logic [W-1:0]    acc_res, pass_res;
  logic            acc_sat;
  logic [psum_bw:0]   lane_sum [col];
  logic [psum_bw-1:0] lane_val [col];

  assign row_addr = base_q + idx_q[aw-1:0];

  // One guard bit per lane: the sum overflowed when the guard and sign bits differ.
  always_comb begin
    acc_res  = '0;
    pass_res = '0;
    acc_sat  = 1'b0;
    for (int i = 0; i < col; i++) begin
      lane_sum[i] = {row_q[i*psum_bw+psum_bw-1], row_q[i*psum_bw +: psum_bw]}
                  + {sram_q[i*psum_bw+psum_bw-1], sram_q[i*psum_bw +: psum_bw]};
      if (lane_sum[i][psum_bw] != lane_sum[i][psum_bw-1]) begin
        acc_sat     = 1'b1;
        lane_val[i] = lane_sum[i][psum_bw] ? MIN_V : MAX_V;
      end else begin
        lane_val[i] = lane_sum[i][psum_bw-1:0];
      end
      if (relu_q && lane_val[i][psum_bw-1]) lane_val[i] = '0;
      acc_res[i*psum_bw +: psum_bw]  = lane_val[i];
      pass_res[i*psum_bw +: psum_bw] = (relu_q && ofifo_out[i*psum_bw+psum_bw-1])
                                       ? '0 : ofifo_out[i*psum_bw +: psum_bw];
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    base_d  = base_q;
    acc_d   = acc_q;
    relu_d  = relu_q;
    sat_d   = sat_q;
    row_d   = row_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (start) begin
        n_d     = n_rows;
        base_d  = base_addr;
        acc_d   = acc_en;
        relu_d  = relu_en;
        sat_d   = 1'b0;
        idx_d   = '0;
        state_d = (n_rows == '0) ? FIN : POP;
      end
      POP: if (ofifo_valid) begin
        row_d = ofifo_out;
        if (acc_q) begin
          state_d = ACC;
        end else begin
          res_d   = pass_res;
          state_d = WR;
        end
      end
      ACC: begin
        res_d   = acc_res;
        sat_d   = sat_q | acc_sat;
        state_d = WR;
      end
      WR: begin
        idx_d   = idx_q + ONE;
        state_d = (idx_q + ONE == n_q) ? FIN : POP;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      acc_q   <= 1'b0;
      relu_q  <= 1'b0;
      sat_q   <= 1'b0;
      row_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      relu_q  <= relu_d;
      sat_q   <= sat_d;
      row_q   <= row_d;
      res_q   <= res_d;
    end
  end

  // Strobes decode straight from the state flops so a reset clears them at once.
  always_comb begin
    ofifo_rd = 1'b0;
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    case (state_q)
      POP: if (ofifo_valid) begin
        ofifo_rd = 1'b1;
        sram_cen = ~acc_q;
      end
      WR: begin
        sram_cen = 1'b0;
        sram_wen = 1'b0;
      end
      default: ;
    endcase
  end

  assign sram_addr = row_addr;
  assign sram_d    = res_q;
  assign busy      = (state_q == POP) || (state_q == ACC) || (state_q == WR);
  assign done      = (state_q == FIN);
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_psum_writeback.sv
// Randomized scoreboard bench for psum_writeback with an SRAM/OFIFO environment
// and a lane-arithmetic reference model.
module tb_psum_writeback;
  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int AW  = 4;
  localparam int W   = COL * PBW;
  localparam int DEPTH = 1 << AW;
  localparam int MAXI = (1 << (PBW-1)) - 1;
  localparam int MINI = -(1 << (PBW-1));

  typedef struct { logic [AW-1:0] a; logic [W-1:0] d; } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [AW:0] n_rows = '0;
  logic [AW-1:0] base_addr = '0;
  logic acc_en = 1'b0, relu_en = 1'b0;
  logic ofifo_valid = 1'b0;
  logic [W-1:0] ofifo_out = '0;
  logic ofifo_rd, sram_cen, sram_wen, busy, done, sat_flag;
  logic [AW-1:0] sram_addr;
  logic [W-1:0] sram_d;
  logic [W-1:0] sram_q = '0;

  psum_writeback #(.col(COL), .psum_bw(PBW), .aw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .n_rows(n_rows), .base_addr(base_addr),
    .acc_en(acc_en), .relu_en(relu_en), .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out),
    .ofifo_rd(ofifo_rd), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_d(sram_d), .sram_q(sram_q), .busy(busy), .done(done), .sat_flag(sat_flag));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int done_cnt = 0;
  int cyc = 0, stall_end = 0, rd_ptr = 0, pl_ptr = 0;
  logic [W-1:0] row_buf [$];
  wr_t pl_q [$];
  wr_t exp_q [$];
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] ref_mem [DEPTH];
  logic e_rd, e_cen, e_wen;
  logic [AW-1:0] e_addr;
  logic [W-1:0] e_d;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // SRAM with 1-cycle read latency, OFIFO fed from row_buf, preload queue.
  always @(posedge clk) begin
    e_rd = ofifo_rd; e_cen = sram_cen; e_wen = sram_wen; e_addr = sram_addr; e_d = sram_d;
    #1;
    cyc++;
    if (!reset) rd_ptr = row_buf.size();
    else if (e_rd && rd_ptr < row_buf.size()) rd_ptr++;
    while (pl_ptr < pl_q.size()) begin
      mem[pl_q[pl_ptr].a] = pl_q[pl_ptr].d;
      pl_ptr++;
    end
    if (!e_cen && !e_wen) mem[e_addr] = e_d;
    else if (!e_cen) sram_q = mem[e_addr];
    ofifo_valid = (rd_ptr < row_buf.size()) && (cyc >= stall_end);
    ofifo_out = (rd_ptr < row_buf.size()) ? row_buf[rd_ptr] : '0;
  end

  // Monitor: every SRAM write is matched against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (ofifo_rd) chk("rd_needs_valid", W'(ofifo_valid), W'(1));
    if (!sram_cen && !sram_wen) begin
      chk("busy_during_write", W'(busy), W'(1));
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual=addr %0h required=no write", sram_addr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", W'(sram_addr), W'(e.a));
        chk("wr_data", sram_d, e.d);
      end
    end
  end

  function automatic logic [W-1:0] model_row(input logic [W-1:0] row, input logic [W-1:0] old,
                                             input bit acc, input bit relu, output bit sat);
    logic [W-1:0] r;
    int v;
    r = '0; sat = 1'b0;
    for (int i = 0; i < COL; i++) begin
      v = int'($signed(row[i*PBW +: PBW]));
      if (acc) v = v + int'($signed(old[i*PBW +: PBW]));
      if (v > MAXI) begin v = MAXI; sat = 1'b1; end
      else if (v < MINI) begin v = MINI; sat = 1'b1; end
      if (relu && v < 0) v = 0;
      r[i*PBW +: PBW] = v[PBW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PBW +: PBW] = PBW'($urandom);
    return r;
  endfunction

  task automatic preload(input int a, input logic [W-1:0] d);
    wr_t p;
    p.a = AW'(a); p.d = d;
    pl_q.push_back(p);
    ref_mem[a] = d;
  endtask

  task automatic start_job(input int n, input int base, input bit acc, input bit relu);
    @(negedge clk);
    n_rows = (AW+1)'(n); base_addr = AW'(base); acc_en = acc; relu_en = relu; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ok, output bit acc_seen);
    lat = 0; ok = 1'b0; acc_seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done) begin ok = 1'b1; lat = k; break; end
      if (!sram_cen) acc_seen = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic run_job(input int n, input int base, input bit acc, input bit relu,
                         input bit stall_mode, input logic [W-1:0] rows [$]);
    int d0, lat, stalls;
    bit ok, acc_seen, exp_sat, s, got;
    wr_t e;
    exp_sat = 1'b0;
    for (int r = 0; r < n; r++) begin
      e.a = AW'((base + r) % DEPTH);
      e.d = model_row(rows[r], ref_mem[e.a], acc, relu, s);
      ref_mem[e.a] = e.d;
      exp_sat |= s;
      exp_q.push_back(e);
      row_buf.push_back(rows[r]);
    end
    d0 = done_cnt;
    start_job(n, base, acc, relu);
    if (stall_mode) begin
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
        if (!sram_cen && !sram_wen) got = 1'b1;
        else @(negedge clk);
      end
      chk("first_write_seen", W'(got), W'(1));
      stall_end = cyc + 5;
      n_rows = 1; base_addr = 9; acc_en = ~acc; relu_en = ~relu; start = 1'b1;
      stalls = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (k == 0) start = 1'b0;
        if (!ofifo_valid) begin
          stalls++;
          chk("stall_rd", W'(ofifo_rd), W'(0));
          chk("stall_cen", W'(sram_cen), W'(1));
        end
      end
      chk("stall_cycles", W'(stalls), W'(4));
    end
    wait_done(lat, ok, acc_seen);
    chk("done_seen", W'(ok), W'(1));
    if (!stall_mode) chk("latency", W'(lat), W'(n * (acc ? 3 : 2)));
    if (n == 0) chk("no_access", W'(acc_seen), W'(0));
    @(negedge clk); @(negedge clk);
    chk("done_once", W'(done_cnt - d0), W'(1));
    chk("sat_flag", W'(sat_flag), W'(exp_sat));
    chk("busy_after", W'(busy), W'(0));
    chk("exp_drained", W'(exp_q.size()), W'(0));
  endtask

  task automatic reset_during_acc();
    int d0;
    bit got;
    for (int r = 0; r < 3; r++) row_buf.push_back(rand_row());
    d0 = done_cnt;
    start_job(3, 5, 1'b1, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      if (!sram_cen && sram_wen) got = 1'b1;
      else @(negedge clk);
    end
    chk("pop_read_seen", W'(got), W'(1));
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_rd", W'(ofifo_rd), W'(0));
    chk("rst_cen", W'(sram_cen), W'(1));
    chk("rst_wen", W'(sram_wen), W'(1));
    chk("rst_addr", W'(sram_addr), W'(0));
    chk("rst_d", sram_d, W'(0));
    chk("rst_busy", W'(busy), W'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_no_done", W'(done_cnt - d0), W'(0));
    chk("rst_idle", W'(busy), W'(0));
  endtask

  initial begin
    logic [W-1:0] rows [$];
    logic [W-1:0] v;
    #2;
    chk("init_rd", W'(ofifo_rd), W'(0));
    chk("init_cen", W'(sram_cen), W'(1));
    chk("init_wen", W'(sram_wen), W'(1));
    chk("init_addr", W'(sram_addr), W'(0));
    chk("init_d", sram_d, W'(0));
    chk("init_busy", W'(busy), W'(0));
    chk("init_done", W'(done), W'(0));
    chk("init_sat", W'(sat_flag), W'(0));
    for (int a = 0; a < DEPTH; a++) preload(a, rand_row());
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    rows.delete();
    v = rand_row(); v[PBW-1:0] = PBW'(5);  rows.push_back(v);
    v = rand_row(); v[PBW-1:0] = PBW'(-7); rows.push_back(v);
    v = rand_row(); v[PBW-1:0] = PBW'(9);  rows.push_back(v);
    run_job(3, 2, 1'b0, 1'b0, 1'b0, rows);
    v = mem[2]; chk("ow_a2_lane0", W'(v[PBW-1:0]), W'(16'd5));
    v = mem[3]; chk("ow_a3_lane0", W'(v[PBW-1:0]), W'(16'hfff9));
    v = mem[4]; chk("ow_a4_lane0", W'(v[PBW-1:0]), W'(16'd9));

    v = rand_row(); v[PBW-1:0] = PBW'(-10); v[2*PBW-1:PBW] = PBW'(4);
    preload(0, v);
    rows.delete();
    v = rand_row(); v[PBW-1:0] = PBW'(3); v[2*PBW-1:PBW] = PBW'(6); rows.push_back(v);
    run_job(1, 0, 1'b1, 1'b1, 1'b0, rows);
    v = mem[0];
    chk("accrelu_lane0", W'(v[PBW-1:0]), W'(16'd0));
    chk("accrelu_lane1", W'(v[2*PBW-1:PBW]), W'(16'd10));

    v = rand_row(); v[PBW-1:0] = PBW'(32000);
    preload(15, v);
    rows.delete();
    v = rand_row(); v[PBW-1:0] = PBW'(1000); rows.push_back(v);
    rows.push_back(rand_row());
    run_job(2, 15, 1'b1, 1'b0, 1'b0, rows);
    v = mem[15]; chk("sat_lane0", W'(v[PBW-1:0]), W'(16'd32767));
    chk("sat_sticky", W'(sat_flag), W'(1));

    rows.delete();
    for (int r = 0; r < 4; r++) rows.push_back(rand_row());
    run_job(4, 11, 1'b1, 1'b0, 1'b1, rows);

    rows.delete();
    run_job(0, 7, 1'b1, 1'b1, 1'b0, rows);

    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      rows.delete();
      for (int r = 0; r < n; r++) rows.push_back(rand_row());
      run_job(n, $urandom_range(0, DEPTH-1), 1'($urandom), 1'($urandom), 1'b0, rows);
    end

    reset_during_acc();

    rows.delete();
    for (int r = 0; r < 3; r++) rows.push_back(rand_row());
    run_job(3, 14, 1'b1, 1'b1, 1'b0, rows);

    repeat (2) @(negedge clk);
    for (int a = 0; a < DEPTH; a++) chk($sformatf("mem_%0d", a), mem[a], ref_mem[a]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
